swap_ctrl: RTL and testbench

SWAP_CTRL -- requirements
Module: swap_ctrl

---
 rtl/sisc_pkg.sv | 17 +
 rtl/swap_hold.sv | 26 ++
 rtl/swap_ctrl.sv | 103 ++++++++++
 tb/tb_swap_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the register swap controller: FSM state encoding
// and the write-address mux select codes.
package sisc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WR_A = 3'd2,
    ST_WR_B = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_SWAP = 2'd2;

endpackage

// File: rtl/swap_hold.sv
// Capture pair for the two register values being swapped. Both halves load
// together from the register-file read ports while the controller is in READ.
module swap_hold #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              load,
  input  logic [DATA_W-1:0] rd_a_data,
  input  logic [DATA_W-1:0] rd_b_data,
  output logic [DATA_W-1:0] hold_a,
  output logic [DATA_W-1:0] hold_b
);

  // Load both read-port values on the edge that ends the READ cycle.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (load) begin
      hold_a <= rd_a_data;
      hold_b <= rd_b_data;
    end
  end

endmodule

// File: rtl/swap_ctrl.sv
// Swaps the contents of two register-file entries using one read cycle and
// two write cycles through the write-address mux swap input.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; ra/rb latched on acceptance
// READ    | read ports addressed by latched ra/rb; holds capture data
// WR_A    | write hold_b into register ra
// WR_B    | write hold_a into register rb
// DONE    | one-cycle completion pulse
module swap_ctrl
  import sisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  input  logic [DATA_W-1:0] rd_a_data,
  input  logic [DATA_W-1:0] rd_b_data,
  output logic [1:0]        wr_sel,
  output logic [ADDR_W-1:0] swap_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [ADDR_W-1:0]   ra_q;
  logic [ADDR_W-1:0]   rb_q;
  logic [DATA_W-1:0]   hold_a;
  logic [DATA_W-1:0]   hold_b;

  swap_hold #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst_f     (rst_f),
    .load      (state == ST_READ),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .hold_a    (hold_a),
    .hold_b    (hold_b)
  );

  // State register and address latch; start is only honoured in IDLE.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= ST_IDLE;
      ra_q  <= '0;
      rb_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra_q  <= ra;
            rb_q  <= rb;
            state <= ST_READ;
          end
        end
        ST_READ: state <= (ra_q != rb_q) ? ST_WR_A : ST_DONE;
        ST_WR_A: state <= ST_WR_B;
        ST_WR_B: state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_a_addr = ra_q;
  assign rd_b_addr = rb_q;

  // Output decode from registered state only, so reset clears it at once
  // and start has no path to the write port.
  always_comb begin
    wr_en     = 1'b0;
    wr_sel    = SEL_A;
    swap_addr = '0;
    wr_data   = '0;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_WR_A: begin
        wr_en     = 1'b1;
        wr_sel    = SEL_SWAP;
        swap_addr = ra_q;
        wr_data   = hold_b;
      end
      ST_WR_B: begin
        wr_en     = 1'b1;
        wr_sel    = SEL_SWAP;
        swap_addr = rb_q;
        wr_data   = hold_a;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_swap_ctrl.sv
// Self-checking bench for swap_ctrl: a behavioural register file around the
// DUT, a reference array holding the expected register contents, and
// directed plus randomized swaps.
module tb_swap_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [AW-1:0] IN_A = 4'hE;
  localparam logic [AW-1:0] IN_B = 4'hD;

  logic          clk = 1'b0;
  logic          rst_f = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [AW-1:0] rb = '0;
  logic [AW-1:0] rd_a_addr, rd_b_addr, swap_addr;
  logic [DW-1:0] rd_a_data, rd_b_data, wr_data;
  logic [1:0]    wr_sel;
  logic          wr_en, busy, done;

  logic [DW-1:0] rf [16];
  logic [DW-1:0] pl_img [16];
  logic [DW-1:0] mdl [16];
  logic          pl_en = 1'b0;
  logic [AW-1:0] wa;
  logic [AW-1:0] w_addr [256];
  logic [DW-1:0] w_data [256];
  int wr_cnt = 0, done_cnt = 0, bad_sel = 0, bad_idle = 0;
  int n_chk = 0, n_err = 0;

  swap_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .start     (start),
    .ra        (ra),
    .rb        (rb),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .wr_sel    (wr_sel),
    .swap_addr (swap_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign rd_a_data = rf[rd_a_addr];
  assign rd_b_data = rf[rd_b_addr];

  // Register file and monitors, sampled mid-cycle away from the DUT edge.
  always @(negedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 16; i++) rf[i] <= pl_img[i];
    end else if (wr_en) begin
      wa = (wr_sel == 2'd2) ? swap_addr : (wr_sel == 2'd1) ? IN_B : IN_A;
      rf[wa] <= wr_data;
      w_addr[wr_cnt % 256] <= wa;
      w_data[wr_cnt % 256] <= wr_data;
      wr_cnt <= wr_cnt + 1;
      if (wr_sel != 2'd2) bad_sel <= bad_sel + 1;
    end
    if (!wr_en && (wr_sel != 0 || swap_addr != 0 || wr_data != 0)) bad_idle <= bad_idle + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_img;
    for (int i = 0; i < 16; i++) pl_img[i] = mdl[i];
    pl_en = 1'b1;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== mdl[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // One swap from acceptance through the first IDLE cycle; the caller may
  // immediately start another (back-to-back).
  task automatic do_swap(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input bit inj, input bit scr);
    int lat, base_w, base_d, busy_err;
    logic [DW-1:0] t;
    base_w = wr_cnt;
    base_d = done_cnt;
    ra = a; rb = b; start = 1'b1;
    tick;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    lat = 1;
    busy_err = 0;
    while (!done && lat < 12) begin
      if (scr) begin ra = AW'($urandom); rb = AW'($urandom); end
      if (inj && lat == 2) start = 1'b1;
      tick;
      start = 1'b0;
      lat++;
      if (!busy) busy_err++;
    end
    chk("latency", lat, (a == b) ? 2 : 4);
    chk("busy_during", busy_err, 0);
    chk("latched_addr", {rd_a_addr, rd_b_addr}, {a, b});
    if (inj) start = 1'b1;
    tick;
    start = 1'b0;
    chk("idle_after_done", {done, busy}, 0);
    t = mdl[a]; mdl[a] = mdl[b]; mdl[b] = t;
    chk("write_count", wr_cnt - base_w, (a == b) ? 0 : 2);
    chk("done_count", done_cnt - base_d, 1);
    check_rf("rf_contents");
  endtask

  initial begin
    int w0, d0;
    logic [DW-1:0] o0, o15;
    #1 rst_f = 1'b0;
    #2;
    chk("rst_ctrl", {wr_en, busy, done, wr_sel}, 0);
    chk("rst_addr", {swap_addr, rd_a_addr, rd_b_addr}, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_hold", {dut.u_hold.hold_a, dut.u_hold.hold_b}, 0);

    for (int i = 0; i < 16; i++) mdl[i] = DW'($urandom);
    mdl[3] = 16'h1234;
    mdl[9] = 16'hBEEF;
    load_img();
    rst_f = 1'b1;

    // Directed 3<->9, also first start right after reset release.
    w0 = wr_cnt;
    do_swap(4'd3, 4'd9, 1'b0, 1'b0);
    chk("wr1_addr", w_addr[w0 % 256], 3);
    chk("wr1_data", w_data[w0 % 256], 16'hBEEF);
    chk("wr2_addr", w_addr[(w0 + 1) % 256], 9);
    chk("wr2_data", w_data[(w0 + 1) % 256], 16'h1234);

    do_swap(4'd5, 4'd5, 1'b0, 1'b0);
    do_swap(4'd4, 4'd7, 1'b1, 1'b0);

    o0 = mdl[0];
    o15 = mdl[15];
    do_swap(4'd0, 4'd15, 1'b0, 1'b0);
    do_swap(4'd15, 4'd0, 1'b0, 1'b0);
    chk("restore_r0", rf[0], o0);
    chk("restore_r15", rf[15], o15);

    do_swap(4'd6, 4'd11, 1'b0, 1'b1);

    // Reset during WR_A of a 1<->2 swap.
    ra = 4'd1; rb = 4'd2; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("mid_wr_en", wr_en, 1);
    w0 = wr_cnt;
    d0 = done_cnt;
    #2 rst_f = 1'b0;
    #1;
    chk("abort_ctrl", {wr_en, busy, done, wr_sel}, 0);
    chk("abort_addr", {swap_addr, rd_a_addr, rd_b_addr}, 0);
    chk("abort_wdata", wr_data, 0);
    tick;
    tick;
    chk("abort_hold", {dut.u_hold.hold_a, dut.u_hold.hold_b}, 0);
    rst_f = 1'b1;
    tick;
    tick;
    chk("abort_idle", busy, 0);
    chk("abort_writes", wr_cnt - w0, 0);
    chk("abort_done", done_cnt - d0, 0);
    check_rf("abort_rf");

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a, b;
      a = AW'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, 15));
      do_swap(a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    chk("write_sel_code", bad_sel, 0);
    chk("idle_outputs_zero", bad_idle, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
